spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
SPI slave front-end for the Pluto servo firmware. It replaces the EPP strobe/address/data decode with a byte-oriented register bus. The bus carries the same auto-incrementing address, write-strobe and read-strobe semantics that the PWM, dout, watchdog and quadrature register decode consumes. All SPI inputs are oversampled and synchronised into the 40 MHz system clock domain.

Parameters:
AW, 5, register address width; addresses wrap modulo 2^AW.
SYNC, 2, synchroniser flop stages on spi_sclk, spi_ncs and spi_mosi (≥2).

Ports:
clk  in  1  system clock (40 MHz)
reset  in  1  asynchronous active-high reset
spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
spi_ncs  in  1  chip select, active low
spi_mosi  in  1  master-out data, MSB first
spi_miso  out  1  slave-out data, MSB first
spi_miso_oe  out  1  MISO output enable, high while frame active
bus_addr  out  AW  register address for current strobe
bus_wdata  out  8  write data, valid with bus_wr
bus_wr  out  1  one-clk write strobe
bus_rd  out  1  one-clk read strobe (reads may have side effects, e.g. quad latch)
bus_rdata  in  8  read data; must be valid on the clk after bus_rd
frame_active  out  1  high from synced ncs fall to synced ncs rise
byte_err  out  1  one-clk pulse when a frame ends mid-byte

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset values:
  - spi_miso=0, spi_miso_oe=0, bus_addr=0, bus_wdata=0, bus_wr=0, bus_rd=0, frame_active=0, byte_err=0.
  - State=IDLE, bit counter=0.
- Input conditioning:
  - SYNC-stage synchronisers on all three SPI inputs.
  - sclk rise/fall detected from the last two synced samples.
  - SPI timing requirement: SCLK high and low times each ≥5 clk.
- States:
  - IDLE → CMD on synced ncs falling. On entry: bit counter=0, tx shift=8'h00, spi_miso_oe=1.
  - CMD: 8 sclk rises shift MOSI into rx. On the 8th rise, latch dir=rx[7] (1=write, 0=read) and addr=rx[AW-1:0], then enter DATA. If read: bus_rd pulses on the following clk with bus_addr=addr.
  - DATA, write: on each 8th rise, bus_wr pulses on the next clk with bus_addr=addr and bus_wdata=byte. addr increments on the clk after bus_wr.
  - DATA, read: on each 8th rise, addr increments, then bus_rd pulses with the new addr. MOSI is ignored in this mode.
  - Any state → IDLE on synced ncs rising. On entry: spi_miso_oe=0, counters cleared.
- MISO:
  - spi_miso = tx[7].
  - tx shifts left on sclk falls only while bit counter ≠0, so the fall following the 8th rise does not shift.
  - The clk after any bus_rd, tx ← bus_rdata. This completes before the next falling sclk edge, given the timing rule above.
  - Master receives 0x00 during the command byte, then data for addr, addr+1, …
- Prefetch: in read frames, one bus_rd is issued for the byte after the last byte clocked. This is required behaviour.
- bus_wr and bus_rd never assert in the same clk. Each asserts for exactly one clk per byte.
- Address wrap: addr = 2^AW−1 increments to 0. No error is raised.
- ncs rises with bit counter ≠0:
  - byte_err pulses for one clk.
  - The partial byte is discarded and no bus strobe is issued for it.
  - A strobe already scheduled from the previous complete byte still issues.
- ncs rises at a byte boundary: clean end, no byte_err.
- ncs falls again within the same frame's teardown: a new frame starts only after synced ncs has been seen high for ≥1 clk.
- Reset mid-frame: all outputs return to reset values immediately. Pending strobes are dropped. After release, the block waits for a fresh ncs fall; a frame already in progress is ignored until ncs goes high.

Test Plan:
- Write burst: frame 0x80, 0x34, 0x12 → bus_wr addr0/0x34, then addr1/0x12; no bus_rd; frame_active drops after ncs high.
- Read burst with model bus_rdata=0x40+addr: frame 0x02 + 3 dummy bytes → MISO bytes 0x00, 0x42, 0x43, 0x44; bus_rd at addrs 2, 3, 4, 5 (5 = prefetch).
- Wrap: frame 0x9F, 0xAA, 0xBB → bus_wr addr31/0xAA, then addr0/0xBB.
- Abort: frame 0x80, 0x55, then ncs high after 4 bits of the next byte → single bus_wr addr0/0x55, one byte_err pulse, no second strobe.
- Reset mid-frame: assert reset during the 2nd data byte of a write frame → all outputs 0 immediately, no strobe. After release with ncs still low, nothing happens until ncs cycles high then low.
- Minimum timing: SCLK high/low = 5 clk in a read frame → MISO bits match the model with zero errors over 256 random addresses.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave that turns byte frames into auto-incrementing register bus strobes
module spi_reg_bridge #(
   parameter int AW   = 5,
   parameter int SYNC = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          spi_sclk,
   input  logic          spi_ncs,
   input  logic          spi_mosi,
   output logic          spi_miso,
   output logic          spi_miso_oe,
   output logic [AW-1:0] bus_addr,
   output logic [7:0]    bus_wdata,
   output logic          bus_wr,
   output logic          bus_rd,
   input  logic [7:0]    bus_rdata,
   output logic          frame_active,
   output logic          byte_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CMD  = 2'd1;
   localparam logic [1:0] DATA = 2'd2;

   logic [SYNC-1:0] sclk_sq, ncs_sq, mosi_sq;
   logic            sclk_prev_q, ncs_prev_q;
   logic [1:0]      state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      rx_q, rx_d, tx_q, tx_d;
   logic            dir_q, dir_d;
   logic [AW-1:0]   addr_q, addr_d, bus_addr_q, bus_addr_d;
   logic [7:0]      bus_wdata_q, bus_wdata_d;
   logic            bus_wr_q, bus_wr_d, bus_rd_q, bus_rd_d;
   logic            rd_load_q, rd_load_d;
   logic            byte_err_q, byte_err_d;

   logic       sclk_s, ncs_s, mosi_s;
   logic       sclk_rise, sclk_fall, ncs_fall, ncs_rise, byte_done;
   logic [7:0] rx_byte;

   // Synchronise the SPI pins; ncs resets low so a frame already in progress at reset release is not seen as a fall
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sq     <= '0;
         ncs_sq      <= '0;
         mosi_sq     <= '0;
         sclk_prev_q <= 1'b0;
         ncs_prev_q  <= 1'b0;
      end else begin
         sclk_sq     <= {sclk_sq[SYNC-2:0], spi_sclk};
         ncs_sq      <= {ncs_sq[SYNC-2:0], spi_ncs};
         mosi_sq     <= {mosi_sq[SYNC-2:0], spi_mosi};
         sclk_prev_q <= sclk_sq[SYNC-1];
         ncs_prev_q  <= ncs_sq[SYNC-1];
      end
   end

   assign sclk_s    = sclk_sq[SYNC-1];
   assign ncs_s     = ncs_sq[SYNC-1];
   assign mosi_s    = mosi_sq[SYNC-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign ncs_fall  = ncs_prev_q & ~ncs_s;
   assign ncs_rise  = ~ncs_prev_q & ncs_s;
   assign rx_byte   = {rx_q[6:0], mosi_s};
   assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

   // Frame sequencing: command byte picks direction and start address, each further byte strobes the bus
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      dir_d       = dir_q;
      addr_d      = addr_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_wr_d    = 1'b0;
      bus_rd_d    = 1'b0;
      rd_load_d   = bus_rd_q;
      byte_err_d  = 1'b0;
      if (state_q == IDLE) begin
         rd_load_d = 1'b0;
         if (ncs_fall) begin
            state_d   = CMD;
            bit_cnt_d = 3'd0;
            rx_d      = 8'h00;
            tx_d      = 8'h00;
         end
      end else if (ncs_rise) begin
         state_d    = IDLE;
         byte_err_d = bit_cnt_q != 3'd0;
         bit_cnt_d  = 3'd0;
         tx_d       = 8'h00;
         rd_load_d  = 1'b0;
      end else begin
         if (rd_load_q)
            tx_d = bus_rdata;
         else if (sclk_fall && bit_cnt_q != 3'd0)
            tx_d = {tx_q[6:0], 1'b0};
         if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            rx_d      = rx_byte;
         end
         if (byte_done) begin
            if (state_q == CMD) begin
               state_d = DATA;
               dir_d   = rx_byte[7];
               addr_d  = rx_byte[AW-1:0];
               if (!rx_byte[7]) begin
                  bus_rd_d   = 1'b1;
                  bus_addr_d = rx_byte[AW-1:0];
               end
            end else if (dir_q) begin
               bus_wr_d    = 1'b1;
               bus_addr_d  = addr_q;
               bus_wdata_d = rx_byte;
               addr_d      = addr_q + AW'(1);
            end else begin
               bus_rd_d   = 1'b1;
               addr_d     = addr_q + AW'(1);
               bus_addr_d = addr_q + AW'(1);
            end
         end
      end
   end

   // Frame state and bus output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         rx_q        <= 8'h00;
         tx_q        <= 8'h00;
         dir_q       <= 1'b0;
         addr_q      <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= 8'h00;
         bus_wr_q    <= 1'b0;
         bus_rd_q    <= 1'b0;
         rd_load_q   <= 1'b0;
         byte_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         dir_q       <= dir_d;
         addr_q      <= addr_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wr_q    <= bus_wr_d;
         bus_rd_q    <= bus_rd_d;
         rd_load_q   <= rd_load_d;
         byte_err_q  <= byte_err_d;
      end
   end

   assign spi_miso     = tx_q[7];
   assign spi_miso_oe  = state_q != IDLE;
   assign frame_active = state_q != IDLE;
   assign bus_addr     = bus_addr_q;
   assign bus_wdata    = bus_wdata_q;
   assign bus_wr       = bus_wr_q;
   assign bus_rd       = bus_rd_q;
   assign byte_err     = byte_err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed SPI frames against a register bus model with rdata = 0x40 + addr
module tb_spi_reg_bridge;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          spi_sclk = 1'b0;
   logic          spi_ncs = 1'b1;
   logic          spi_mosi = 1'b0;
   logic          spi_miso, spi_miso_oe, bus_wr, bus_rd, frame_active, byte_err;
   logic [AW-1:0] bus_addr;
   logic [7:0]    bus_wdata;
   logic [7:0]    bus_rdata = 8'h00;

   int vec = 0;
   int miss = 0;
   int wr_n = 0;
   int rd_n = 0;
   int err_n = 0;
   int both_n = 0;
   logic [7:0] wr_a [0:2047];
   logic [7:0] wr_d [0:2047];
   logic [7:0] rd_a [0:2047];

   always #5 clk = ~clk;

   spi_reg_bridge #(.AW(AW), .SYNC(2)) dut (
      .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_ncs(spi_ncs), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_rdata(bus_rdata), .frame_active(frame_active),
      .byte_err(byte_err)
   );

   // Register file model: read data appears the clk after bus_rd
   always @(posedge clk) if (bus_rd) bus_rdata <= 8'h40 + 8'(bus_addr);

   // Bus monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (bus_wr && wr_n < 2048) begin
         wr_a[wr_n] = 8'(bus_addr);
         wr_d[wr_n] = bus_wdata;
         wr_n++;
      end
      if (bus_rd && rd_n < 2048) begin
         rd_a[rd_n] = 8'(bus_addr);
         rd_n++;
      end
      if (bus_wr && bus_rd) both_n++;
      if (byte_err) err_n++;
   end

   task automatic spi_bits(input logic [7:0] b, input int n, input int h, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         spi_mosi = b[i];
         repeat (h) @(negedge clk);
         spi_sclk = 1'b1;
         r[i] = spi_miso;
         repeat (h) @(negedge clk);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic frame_begin(input int h);
      spi_ncs = 1'b0;
      repeat (h) @(negedge clk);
   endtask

   task automatic frame_end(input int h);
      repeat (h) @(negedge clk);
      spi_ncs = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset;
      #1;
      vec++;
      if ({spi_miso, spi_miso_oe, bus_wr, bus_rd, frame_active, byte_err} !== 6'b0) begin
         miss++;
         $display("FAIL reset_ctrl got %b want 000000", {spi_miso, spi_miso_oe, bus_wr, bus_rd, frame_active, byte_err});
      end
      vec++;
      if ({bus_addr, bus_wdata} !== '0) begin
         miss++;
         $display("FAIL reset_bus got addr=%h wdata=%h want 0/0", bus_addr, bus_wdata);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_write;
      logic [7:0] r;
      int w0, r0, e0;
      w0 = wr_n; r0 = rd_n; e0 = err_n;
      frame_begin(6);
      spi_bits(8'h80, 8, 6, r);
      spi_bits(8'h34, 8, 6, r);
      spi_bits(8'h12, 8, 6, r);
      vec++;
      if ({frame_active, spi_miso_oe} !== 2'b11) begin
         miss++;
         $display("FAIL write_active got %b want 11", {frame_active, spi_miso_oe});
      end
      frame_end(6);
      vec++;
      if (wr_n - w0 !== 2) begin
         miss++;
         $display("FAIL write_count got %0d want 2", wr_n - w0);
      end
      vec++;
      if ({wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1]} !== 32'h00_34_01_12) begin
         miss++;
         $display("FAIL write_data got %h/%h %h/%h want 00/34 01/12", wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1]);
      end
      vec++;
      if ({rd_n - r0, err_n - e0} !== {32'd0, 32'd0}) begin
         miss++;
         $display("FAIL write_norderr got rd=%0d err=%0d want 0/0", rd_n - r0, err_n - e0);
      end
      vec++;
      if ({frame_active, spi_miso_oe} !== 2'b00) begin
         miss++;
         $display("FAIL write_idle got %b want 00", {frame_active, spi_miso_oe});
      end
   endtask

   task automatic test_read;
      logic [7:0] r0, r1, r2, r3;
      int w0, q0;
      w0 = wr_n; q0 = rd_n;
      frame_begin(6);
      spi_bits(8'h02, 8, 6, r0);
      spi_bits(8'hFF, 8, 6, r1);
      spi_bits(8'hFF, 8, 6, r2);
      spi_bits(8'hFF, 8, 6, r3);
      frame_end(6);
      vec++;
      if ({r0, r1, r2, r3} !== 32'h00_42_43_44) begin
         miss++;
         $display("FAIL read_miso got %h %h %h %h want 00 42 43 44", r0, r1, r2, r3);
      end
      vec++;
      if (rd_n - q0 !== 4) begin
         miss++;
         $display("FAIL read_count got %0d want 4", rd_n - q0);
      end
      vec++;
      if ({rd_a[q0], rd_a[q0+1], rd_a[q0+2], rd_a[q0+3]} !== 32'h02_03_04_05) begin
         miss++;
         $display("FAIL read_addr got %h %h %h %h want 02 03 04 05", rd_a[q0], rd_a[q0+1], rd_a[q0+2], rd_a[q0+3]);
      end
      vec++;
      if (wr_n - w0 !== 0) begin
         miss++;
         $display("FAIL read_nowr got %0d want 0", wr_n - w0);
      end
   endtask

   task automatic test_wrap;
      logic [7:0] r;
      int w0;
      w0 = wr_n;
      frame_begin(6);
      spi_bits(8'h9F, 8, 6, r);
      spi_bits(8'hAA, 8, 6, r);
      spi_bits(8'hBB, 8, 6, r);
      frame_end(6);
      vec++;
      if (wr_n - w0 !== 2) begin
         miss++;
         $display("FAIL wrap_count got %0d want 2", wr_n - w0);
      end
      vec++;
      if ({wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1]} !== 32'h1F_AA_00_BB) begin
         miss++;
         $display("FAIL wrap_data got %h/%h %h/%h want 1f/aa 00/bb", wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1]);
      end
   endtask

   task automatic test_abort;
      logic [7:0] r;
      int w0, e0;
      w0 = wr_n; e0 = err_n;
      frame_begin(6);
      spi_bits(8'h80, 8, 6, r);
      spi_bits(8'h55, 8, 6, r);
      spi_bits(8'hC3, 4, 6, r);
      frame_end(6);
      vec++;
      if (wr_n - w0 !== 1) begin
         miss++;
         $display("FAIL abort_count got %0d want 1", wr_n - w0);
      end
      vec++;
      if ({wr_a[w0], wr_d[w0]} !== 16'h00_55) begin
         miss++;
         $display("FAIL abort_data got %h/%h want 00/55", wr_a[w0], wr_d[w0]);
      end
      vec++;
      if (err_n - e0 !== 1) begin
         miss++;
         $display("FAIL abort_err got %0d want 1", err_n - e0);
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] r;
      int w0, q0;
      w0 = wr_n; q0 = rd_n;
      frame_begin(6);
      spi_bits(8'h80, 8, 6, r);
      spi_bits(8'hAA, 8, 6, r);
      spi_bits(8'hF0, 3, 6, r);
      reset = 1'b1;
      #1;
      vec++;
      if ({spi_miso, spi_miso_oe, bus_wr, bus_rd, frame_active, byte_err} !== 6'b0) begin
         miss++;
         $display("FAIL midrst_ctrl got %b want 000000", {spi_miso, spi_miso_oe, bus_wr, bus_rd, frame_active, byte_err});
      end
      vec++;
      if ({bus_addr, bus_wdata} !== '0) begin
         miss++;
         $display("FAIL midrst_bus got addr=%h wdata=%h want 0/0", bus_addr, bus_wdata);
      end
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      spi_bits(8'hFF, 8, 6, r);
      spi_bits(8'h81, 8, 6, r);
      vec++;
      if ({frame_active, spi_miso_oe} !== 2'b00) begin
         miss++;
         $display("FAIL midrst_ignored got %b want 00", {frame_active, spi_miso_oe});
      end
      frame_end(6);
      vec++;
      if (wr_n - w0 !== 1) begin
         miss++;
         $display("FAIL midrst_nostrobe got %0d want 1", wr_n - w0);
      end
      frame_begin(6);
      spi_bits(8'h83, 8, 6, r);
      spi_bits(8'h77, 8, 6, r);
      frame_end(6);
      vec++;
      if (wr_n - w0 !== 2 || {wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1]} !== 32'h00_AA_03_77) begin
         miss++;
         $display("FAIL midrst_recover got n=%0d %h/%h %h/%h want 2 00/aa 03/77", wr_n - w0, wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1]);
      end
      vec++;
      if (rd_n - q0 !== 0) begin
         miss++;
         $display("FAIL midrst_nord got %0d want 0", rd_n - q0);
      end
   endtask

   task automatic test_min_timing;
      logic [7:0] r0, r1, exp;
      logic [4:0] a;
      int q0;
      for (int k = 0; k < 256; k++) begin
         a = 5'($urandom_range(0, 31));
         exp = 8'h40 + {3'b000, a};
         q0 = rd_n;
         frame_begin(5);
         spi_bits({3'b000, a}, 8, 5, r0);
         spi_bits(8'hFF, 8, 5, r1);
         frame_end(5);
         vec++;
         if ({r0, r1} !== {8'h00, exp}) begin
            miss++;
            $display("FAIL mintime_miso addr=%0d got %h %h want 00 %h", a, r0, r1, exp);
         end
         vec++;
         if (rd_n - q0 !== 2 || rd_a[q0] !== {3'b000, a}) begin
            miss++;
            $display("FAIL mintime_rd addr=%0d got n=%0d first=%h want 2 %h", a, rd_n - q0, rd_a[q0], {3'b000, a});
         end
      end
   endtask

   initial begin
      test_reset;
      test_write;
      test_read;
      test_wrap;
      test_abort;
      test_reset_mid_frame;
      test_min_timing;
      vec++;
      if (both_n !== 0) begin
         miss++;
         $display("FAIL wr_rd_overlap got %0d want 0", both_n);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
